mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS datapath.
- Sits directly downstream of the register file: consumes the latched rs/rt operand words.
- Executes MULT/MULTU/DIV/DIVU over ~34 cycles; the control FSM stalls on busy.
- Its hi/lo outputs feed the write-back mux so MFHI/MFLO can write the register file.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count = WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  launch operation (one-cycle pulse from control FSM)
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  WIDTH  MTHI/MTLO data (rs)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: new HI/LO valid
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0; internal accumulators=0. Applies at any time, including mid-operation; the partial result is discarded.
- States:
  - IDLE: start=1 latches op, |a|, |b| (magnitudes for signed ops, raw for unsigned) and the sign flags, clears counter, goes to CALC. This is edge E0.
  - CALC: one iteration per edge, counter++. After WIDTH iterations (edges E1..E32) goes to FIX.
  - FIX: sign correction; writes hi/lo; done=1; goes to IDLE. This is edge E33.
- busy = (state != IDLE): high in the cycles after E0 through E33; low in the done cycle.
- Latency: start edge to hi/lo update is 33 edges; done is high exactly in the cycle after E33.
- Multiply:
  - Shift-add over a 2*WIDTH accumulator.
  - Signed: product negated (two's complement over 2*WIDTH) when sign(a) != sign(b).
  - hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide:
  - Restoring, one quotient bit per iteration.
  - lo = quotient, hi = remainder.
  - Signed: quotient negated if signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
- Divide by zero (b==0, DIV or DIVU): full latency; lo=0xFFFFFFFF, hi=a unmodified; sign fix suppressed.
- start while busy: ignored. start in the done cycle: accepted (state is IDLE).
- mthi/mtlo:
  - Honoured only in IDLE with start=0; write takes effect at the next edge.
  - Ignored while busy; start in the same cycle has priority.
  - mthi and mtlo together write both registers.
- hi/lo hold their values between operations. Operands are captured at E0; a and b may change afterwards.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined: MULT/MULTU leave CALC for FIX as soon as the remaining multiplier bits are all zero, checked at each CALC edge including the first.
  - b==0 gives hi/lo at E2 with done in the following cycle.
  - Divide latency is unchanged.
- Undefined: fixed 33-edge latency for all ops.

Decomposition:
- Package mdu_pkg:
  - typedef enum mdu_op_t {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} (2 bits)
  - typedef enum mdu_state_t {S_IDLE, S_CALC, S_FIX}
  - localparam MDU_WIDTH=32
  - localparam MDU_CNT_W=$clog2(MDU_WIDTH)+1
- One natural sub-module: mdu_signfix (combinational). Computes operand magnitudes at launch and the negate/remainder-sign correction at FIX; keeps the FSM/iteration body in mdu_hilo.

Test Plan:
- MULT a=0xFFFFFFFF, b=2 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFE; done high for exactly 1 cycle; busy high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100; second start pulse at E5 ignored, result unchanged.
- MULTU 3x5 then rst at E10 -> next cycle busy=0, done=0, hi=0, lo=0; new MULTU 3x5 gives lo=15, hi=0.
- mthi wdata=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5; mtlo during busy -> lo unchanged; with MDU_EARLY_TERM_EN, MULTU b=1 -> done in cycle after E2.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } mdu_state_t;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH) + 1;

  function automatic logic op_is_div(input mdu_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Sign handling for mdu_hilo: operand magnitudes at launch and the
// negate / remainder-sign / divide-by-zero correction applied at FIX.
module mdu_signfix
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  mdu_op_t              i_op,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [WIDTH-1:0]     o_mag_a,
  output logic [WIDTH-1:0]     o_mag_b,
  output logic                 o_sign_a,
  output logic                 o_sign_b,
  input  mdu_op_t              i_fix_op,
  input  logic                 i_fix_sa,
  input  logic                 i_fix_sb,
  input  logic                 i_fix_dbz,
  input  logic [2*WIDTH-1:0]   i_prod,
  input  logic [WIDTH-1:0]     i_quo,
  input  logic [WIDTH-1:0]     i_rem,
  output logic [WIDTH-1:0]     o_hi,
  output logic [WIDTH-1:0]     o_lo
);

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  always_comb begin
    o_sign_a = op_is_signed(i_op) & i_a[WIDTH-1];
    o_sign_b = op_is_signed(i_op) & i_b[WIDTH-1];
    o_mag_a  = o_sign_a ? -i_a : i_a;
    o_mag_b  = o_sign_b ? -i_b : i_b;
  end

  // Remainder follows the dividend; with a zero divisor this restores a as-is.
  always_comb begin
    w_prod_fix = (i_fix_sa ^ i_fix_sb) ? -i_prod : i_prod;
    w_quo_fix  = (i_fix_sa ^ i_fix_sb) ? -i_quo  : i_quo;
    w_rem_fix  = i_fix_sa ? -i_rem : i_rem;
    if (op_is_div(i_fix_op)) begin
      o_hi = w_rem_fix;
      o_lo = i_fix_dbz ? {WIDTH{1'b1}} : w_quo_fix;
    end else begin
      o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      o_lo = w_prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional MDU_EARLY_TERM_EN: multiplies finish once remaining multiplier bits are zero.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  mdu_op_t            r_op;
  logic               r_sa;
  logic               r_sb;
  logic               r_dbz;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_dvsr;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;

  mdu_op_t            w_op;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;
  logic [WIDTH-1:0]   w_mpl_next;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic               w_last;

  assign w_op = mdu_op_t'(op);

  mdu_signfix #(.WIDTH(WIDTH)) u_signfix (
    .i_op      (w_op),
    .i_a       (a),
    .i_b       (b),
    .o_mag_a   (w_mag_a),
    .o_mag_b   (w_mag_b),
    .o_sign_a  (w_sa),
    .o_sign_b  (w_sb),
    .i_fix_op  (r_op),
    .i_fix_sa  (r_sa),
    .i_fix_sb  (r_sb),
    .i_fix_dbz (r_dbz),
    .i_prod    (r_prod),
    .i_quo     (r_quo),
    .i_rem     (r_rem),
    .o_hi      (w_fix_hi),
    .o_lo      (w_fix_lo)
  );

  // One shift-add or restoring-subtract step per CALC edge.
  always_comb begin
    w_mpl_next  = r_mplier >> 1;
    w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    w_div_shift = {r_rem, r_quo[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_dvsr};
    w_div_ok    = ~w_div_diff[WIDTH];
    w_rem_next  = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    w_quo_next  = {r_quo[WIDTH-2:0], w_div_ok};
    w_last      = (r_cnt == CNT_W'(WIDTH - 1));
`ifdef MDU_EARLY_TERM_EN
    if (!op_is_div(r_op) && (w_mpl_next == '0)) w_last = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= MDU_MULT;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dbz    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_dvsr   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= w_op;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_dbz    <= (b == '0);
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_prod   <= '0;
            r_dvsr   <= w_mag_b;
            r_quo    <= w_mag_a;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (op_is_div(r_op)) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
          end else begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mpl_next;
          end
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo; latencies adapt when MDU_EARLY_TERM_EN is defined.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;
  int k;
  int bcnt;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Edges from E0 to the hi/lo update plus one (the done cycle index).
  function automatic int lat(input logic [1:0] o, input logic [31:0] y);
    int n;
    n = 33;
`ifdef MDU_EARLY_TERM_EN
    if (!o[1]) begin
      logic [31:0] m;
      m = (!o[0] && y[31]) ? -y : y;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      n = n + 1;
    end
`endif
    return n;
  endfunction

  // Called at a negedge; returns at the negedge right after E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D;
    k = 0; bcnt = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      if (busy) bcnt++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic finish(input string tag, input logic [31:0] eh, input logic [31:0] el, input int elat);
    while (!done && k < 80) step(1);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(k), 32'(elat));
    chk({tag, "_busycyc"}, 32'(bcnt), 32'(elat));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el);
    issue(o, x, y);
    finish(tag, eh, el, lat(o, y));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("mult_m1x2", MDU_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    @(negedge clk);
    chk("mult_m1x2_pulse", 32'(done), 32'd0);

    run("multu_x2", MDU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
    run("mult_negneg", MDU_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'h0000000F);
    run("mult_minsq", MDU_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    run("mult_b0", MDU_MULT, 32'h12345678, 32'h0, 32'h0, 32'h0);
    run("div_m7d2", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    // Started in the done cycle of the previous op.
    run("divu_100d7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run("div_m7d0", MDU_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);

    issue(MDU_DIVU, 32'd100, 32'd0);
    step(4);
    start = 1'b1; op = MDU_MULTU; a = 32'd3; b = 32'd5;
    step(1);
    start = 1'b0;
    finish("divu_d0", 32'd100, 32'hFFFFFFFF, 33);

    @(negedge clk);
    issue(MDU_MULTU, 32'd3, 32'd5);
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    run("multu_3x5", MDU_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

    @(negedge clk);
    mthi = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5A5A5);
    chk("mthi_lo", lo, 32'd15);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo_hi", hi, 32'h12345678);
    chk("mthilo_lo", lo, 32'h12345678);

    mthi = 1'b1; wdata = 32'h11111111;
    issue(MDU_MULTU, 32'd7, 32'd6);
    mthi = 1'b0;
    chk("start_prio_hi", hi, 32'h12345678);
    mtlo = 1'b1; wdata = 32'hDEADBEEF;
    step(1);
    mtlo = 1'b0;
    chk("mtlo_busy_lo", lo, 32'h12345678);
    chk("mtlo_busy_busy", 32'(busy), 32'd1);
    finish("multu_7x6", 32'd0, 32'd42, lat(MDU_MULTU, 32'd6));

    run("multu_b1", MDU_MULTU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
